// File: rtl/srambank_arbiter_pkg.sv
// Bank geometry and request command layout shared by the SRAM bank arbiter slice.
package sram_pkg;

    localparam int unsigned SRAM_DEPTH   = 1024;
    localparam int unsigned SRAM_AW      = $clog2(SRAM_DEPTH);
    localparam int unsigned SRAM_DW      = 32;
    localparam int unsigned SRAM_MAX_REQ = 8;
    localparam int unsigned SRAM_IDW     = $clog2(SRAM_MAX_REQ);

    typedef struct packed {
        logic                 write;
        logic [SRAM_AW-1:0]   addr;
        logic [SRAM_DW-1:0]   wdata;
    } req_cmd_t;

endpackage

// File: rtl/srambank_arbiter_rr_arbiter.sv
// Round-robin picker: first set request at or after rr_ptr, wrapping modulo NUM_REQ.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned IDW     = 3
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDW-1:0]     grant_idx,
    output logic               grant_valid
);

    localparam int unsigned PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    always_comb begin
        int unsigned pos;
        logic [PW-1:0] sel;
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        pos         = 0;
        sel         = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            // rr_ptr is always below NUM_REQ, so one subtraction wraps
            pos = int'(rr_ptr) + k;
            if (pos >= NUM_REQ) begin
                pos = pos - NUM_REQ;
            end
            sel = PW'(pos);
            if (!grant_valid && req[sel]) begin
                grant[sel]  = 1'b1;
                grant_idx   = IDW'(pos);
                grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/srambank_arbiter.sv
// Shares one 1024x32 synchronous SRAM bank among NUM_REQ requesters with a
// registered command stage and a tagged, two-cycle read response path.
module srambank_arbiter
    import sram_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned AW      = SRAM_AW,
    parameter int unsigned DW      = SRAM_DW,
    parameter int unsigned IDW     = SRAM_IDW
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ-1:0]    req_write,
    input  logic [NUM_REQ*AW-1:0] req_addr,
    input  logic [NUM_REQ*DW-1:0] req_wdata,
    output logic [NUM_REQ-1:0]    rsp_valid,
    output logic [DW-1:0]         rsp_data,
    output logic [AW-1:0]         bank_address,
    output logic [DW-1:0]         bank_wd,
    output logic                  bank_banksel,
    output logic                  bank_read,
    output logic                  bank_write,
    input  logic [DW-1:0]         bank_dataout
);

    logic [NUM_REQ-1:0] grant;
    logic [IDW-1:0]     grant_idx;
    logic               grant_valid;
    req_cmd_t           win_cmd;

    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic           banksel_q, banksel_d;
    logic           read_q, read_d;
    logic           write_q, write_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic [DW-1:0]  wd_q, wd_d;
    logic           tag1_valid_q, tag1_valid_d;
    logic [IDW-1:0] tag1_idx_q, tag1_idx_d;
    logic           tag2_valid_q, tag2_valid_d;
    logic [IDW-1:0] tag2_idx_q, tag2_idx_d;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_rr_arbiter (
        .req         (req_valid),
        .rr_ptr      (rr_ptr_q),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    always_comb begin
        win_cmd = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                win_cmd.write = req_write[i];
                win_cmd.addr  = req_addr[i*AW +: AW];
                win_cmd.wdata = req_wdata[i*DW +: DW];
            end
        end
    end

    always_comb begin
        rr_ptr_d     = rr_ptr_q;
        banksel_d    = 1'b0;
        read_d       = 1'b0;
        write_d      = 1'b0;
        addr_d       = addr_q;
        wd_d         = wd_q;
        tag1_valid_d = 1'b0;
        tag1_idx_d   = tag1_idx_q;
        // second tag stage lines up with bank_dataout one cycle after the command
        tag2_valid_d = tag1_valid_q;
        tag2_idx_d   = tag1_idx_q;
        if (grant_valid) begin
            rr_ptr_d     = (grant_idx == IDW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
            banksel_d    = 1'b1;
            write_d      = win_cmd.write;
            read_d       = ~win_cmd.write;
            addr_d       = win_cmd.addr;
            wd_d         = win_cmd.wdata;
            tag1_valid_d = ~win_cmd.write;
            tag1_idx_d   = grant_idx;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr_q     <= '0;
            banksel_q    <= 1'b0;
            read_q       <= 1'b0;
            write_q      <= 1'b0;
            addr_q       <= '0;
            wd_q         <= '0;
            tag1_valid_q <= 1'b0;
            tag1_idx_q   <= '0;
            tag2_valid_q <= 1'b0;
            tag2_idx_q   <= '0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            banksel_q    <= banksel_d;
            read_q       <= read_d;
            write_q      <= write_d;
            addr_q       <= addr_d;
            wd_q         <= wd_d;
            tag1_valid_q <= tag1_valid_d;
            tag1_idx_q   <= tag1_idx_d;
            tag2_valid_q <= tag2_valid_d;
            tag2_idx_q   <= tag2_idx_d;
        end
    end

    always_comb begin
        rsp_valid = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (tag2_valid_q && (tag2_idx_q == IDW'(i))) begin
                rsp_valid[i] = 1'b1;
            end
        end
    end

    assign req_ready    = grant;
    assign rsp_data     = bank_dataout;
    assign bank_address = addr_q;
    assign bank_wd      = wd_q;
    assign bank_banksel = banksel_q;
    assign bank_read    = read_q;
    assign bank_write   = write_q;

endmodule

// File: tb/tb_srambank_arbiter.sv
// Bench for srambank_arbiter with a behavioural bank and a transaction-level reference model.
module tb_srambank_arbiter;

    localparam int N   = 4;
    localparam int AW  = 10;
    localparam int DW  = 32;
    localparam int IDW = 3;

    logic                clk = 1'b0;
    logic                reset;
    logic [N-1:0]        req_valid, req_ready, req_write, rsp_valid;
    logic [N*AW-1:0]     req_addr;
    logic [N*DW-1:0]     req_wdata;
    logic [DW-1:0]       rsp_data, bank_wd, bank_dataout;
    logic [AW-1:0]       bank_address;
    logic                bank_banksel, bank_read, bank_write;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    srambank_arbiter #(
        .NUM_REQ (N),
        .AW      (AW),
        .DW      (DW),
        .IDW     (IDW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_data     (rsp_data),
        .bank_address (bank_address),
        .bank_wd      (bank_wd),
        .bank_banksel (bank_banksel),
        .bank_read    (bank_read),
        .bank_write   (bank_write),
        .bank_dataout (bank_dataout)
    );

    // Synchronous bank: one-cycle read, write at the command edge
    logic [DW-1:0] bank_mem [0:1023];
    always @(posedge clk) begin
        if (bank_banksel && bank_write) bank_mem[bank_address] <= bank_wd;
        if (bank_banksel && bank_read)  bank_dataout <= bank_mem[bank_address];
    end

    // Reference model: accepted transactions in program order
    typedef struct {
        bit            acc;
        bit            wr;
        int            idx;
        logic [AW-1:0] addr;
        logic [DW-1:0] wd;
        logic [DW-1:0] rdata;
    } cmd_t;

    cmd_t          c1, c2;
    int            m_ptr;
    logic [DW-1:0] m_mem [0:1023];
    logic [AW-1:0] last_addr;
    logic [DW-1:0] last_wd;
    logic [N-1:0]  e_ready, e_rsp_valid;
    logic [DW-1:0] e_rsp_data, e_wd;
    logic [AW-1:0] e_addr;
    logic          e_sel, e_rd, e_wr;

    task automatic model_reset();
        m_ptr = 0;
        c1 = '{default: 0};
        c2 = '{default: 0};
        last_addr = '0;
        last_wd = '0;
    endtask

    task automatic model_cycle();
        cmd_t n;
        n = '{default: 0};
        if (c1.acc) begin
            last_addr = c1.addr;
            last_wd = c1.wd;
        end
        e_sel = c1.acc;
        e_rd = c1.acc && !c1.wr;
        e_wr = c1.acc && c1.wr;
        e_addr = last_addr;
        e_wd = last_wd;
        e_rsp_valid = '0;
        e_rsp_data = c2.rdata;
        if (c2.acc && !c2.wr) e_rsp_valid[c2.idx] = 1'b1;
        e_ready = '0;
        for (int k = 0; k < N; k++) begin
            int j;
            j = (m_ptr + k) % N;
            if (!n.acc && req_valid[j]) begin
                n.acc = 1;
                n.idx = j;
                n.wr = req_write[j];
                n.addr = req_addr[j*AW +: AW];
                n.wd = req_wdata[j*DW +: DW];
                n.rdata = m_mem[n.addr];
                if (n.wr) m_mem[n.addr] = n.wd;
                e_ready[j] = 1'b1;
                m_ptr = (j + 1) % N;
            end
        end
        c2 = c1;
        c1 = n;
    endtask

    task automatic drive_idle();
        req_valid = '0;
        req_write = '0;
        req_addr = '0;
        req_wdata = '0;
    endtask

    task automatic set_req(input int i, input logic v, input logic w,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[i] = v;
        req_write[i] = w;
        req_addr[i*AW +: AW] = a;
        req_wdata[i*DW +: DW] = d;
    endtask

    task automatic settle();
        #1;
        model_cycle();
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        drive_idle();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive_idle();
        repeat (2) @(negedge clk);
        checks++;
        if ({req_ready, rsp_valid, bank_banksel, bank_read, bank_write, bank_address, bank_wd} !== '0) begin
            errors++;
            $display("FAIL reset_hold: ready=%b rsp=%b sel=%b rd=%b wr=%b addr=%h wd=%h, all required 0",
                     req_ready, rsp_valid, bank_banksel, bank_read, bank_write, bank_address, bank_wd);
        end
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        drive_idle();
        settle();
        checks++;
        if ({req_ready, rsp_valid, bank_banksel, bank_read, bank_write, bank_address, bank_wd} !== '0) begin
            errors++;
            $display("FAIL reset_idle: ready=%b rsp=%b sel=%b addr=%h wd=%h, all required 0",
                     req_ready, rsp_valid, bank_banksel, bank_address, bank_wd);
        end
    endtask

    task automatic test_write_read();
        @(negedge clk); drive_idle(); set_req(0, 1'b1, 1'b1, 10'h3FF, 32'hDEADBEEF); settle();
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++; $display("FAIL wr_grant: got %b required 0001", req_ready);
        end
        @(negedge clk); drive_idle(); set_req(0, 1'b1, 1'b0, 10'h3FF, '0); settle();
        checks++;
        if ({bank_banksel, bank_write, bank_read, bank_address, bank_wd} !== {3'b110, 10'h3FF, 32'hDEADBEEF}) begin
            errors++;
            $display("FAIL wr_pins: sel/wr/rd=%b%b%b addr=%h wd=%h required 110 3ff deadbeef",
                     bank_banksel, bank_write, bank_read, bank_address, bank_wd);
        end
        @(negedge clk); drive_idle(); settle();
        checks++;
        if ({bank_banksel, bank_write, bank_read, rsp_valid} !== 7'b101_0000) begin
            errors++;
            $display("FAIL rd_pins: sel/wr/rd=%b%b%b rsp=%b required 101 0000",
                     bank_banksel, bank_write, bank_read, rsp_valid);
        end
        @(negedge clk); settle();
        checks++;
        if ({rsp_valid, rsp_data} !== {4'b0001, 32'hDEADBEEF}) begin
            errors++; $display("FAIL rd_rsp: rsp=%b data=%h required 0001 deadbeef", rsp_valid, rsp_data);
        end
        @(negedge clk); settle();
        checks++;
        if ({bank_banksel, rsp_valid} !== 5'b0) begin
            errors++; $display("FAIL rd_after: sel=%b rsp=%b required 0 0000", bank_banksel, rsp_valid);
        end
    endtask

    task automatic test_alternate();
        logic [N-1:0] exp_g, exp_r;
        logic [DW-1:0] exp_d;
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); drive_idle();
            if (i < 6) begin
                set_req(0, 1'b1, 1'b0, 10'h3FF, '0);
                set_req(1, 1'b1, 1'b0, 10'h100, '0);
            end
            settle();
            exp_g = (i >= 6) ? 4'b0000 : ((i % 2 == 0) ? 4'b0001 : 4'b0010);
            checks++;
            if (req_ready !== exp_g) begin
                errors++; $display("FAIL alt_grant[%0d]: got %b required %b", i, req_ready, exp_g);
            end
            exp_r = (i < 2) ? 4'b0000 : (((i - 2) % 2 == 0) ? 4'b0001 : 4'b0010);
            exp_d = ((i - 2) % 2 == 0) ? 32'hDEADBEEF : 32'h0;
            checks++;
            if (rsp_valid !== exp_r || (i >= 2 && rsp_data !== exp_d)) begin
                errors++; $display("FAIL alt_rsp[%0d]: rsp=%b data=%h required %b %h", i, rsp_valid, rsp_data, exp_r, exp_d);
            end
        end
    endtask

    task automatic test_pair23();
        logic [N-1:0] exp_g, exp_r;
        logic [DW-1:0] exp_d;
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); drive_idle();
            if (i < 4) begin
                set_req(2, 1'b1, 1'b0, 10'h3FF, '0);
                set_req(3, 1'b1, 1'b0, 10'h100, '0);
            end
            settle();
            exp_g = (i >= 4) ? 4'b0000 : ((i % 2 == 0) ? 4'b0100 : 4'b1000);
            checks++;
            if (req_ready !== exp_g) begin
                errors++; $display("FAIL wrap_grant[%0d]: got %b required %b", i, req_ready, exp_g);
            end
            if (i >= 2) begin
                exp_r = ((i - 2) % 2 == 0) ? 4'b0100 : 4'b1000;
                exp_d = ((i - 2) % 2 == 0) ? 32'hDEADBEEF : 32'h0;
                checks++;
                if ({rsp_valid, rsp_data} !== {exp_r, exp_d}) begin
                    errors++; $display("FAIL wrap_rsp[%0d]: rsp=%b data=%h required %b %h", i, rsp_valid, rsp_data, exp_r, exp_d);
                end
            end
        end
    endtask

    task automatic test_war();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); drive_idle();
            case (i)
                0: set_req(0, 1'b1, 1'b1, 10'h010, 32'h11111111);
                1: set_req(1, 1'b1, 1'b0, 10'h010, '0);
                2: set_req(0, 1'b1, 1'b1, 10'h010, 32'h22222222);
                3: set_req(1, 1'b1, 1'b0, 10'h010, '0);
                default: ;
            endcase
            settle();
            if (i == 3) begin
                checks++;
                if ({rsp_valid, rsp_data} !== {4'b0010, 32'h11111111}) begin
                    errors++; $display("FAIL war_old: rsp=%b data=%h required 0010 11111111", rsp_valid, rsp_data);
                end
            end
            if (i == 5) begin
                checks++;
                if ({rsp_valid, rsp_data} !== {4'b0010, 32'h22222222}) begin
                    errors++; $display("FAIL war_new: rsp=%b data=%h required 0010 22222222", rsp_valid, rsp_data);
                end
            end
        end
    endtask

    task automatic test_hold();
        apply_reset();
        @(negedge clk); drive_idle();
        set_req(0, 1'b1, 1'b0, 10'h020, '0);
        set_req(1, 1'b1, 1'b0, 10'h030, '0);
        settle();
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++; $display("FAIL hold_first: got %b required 0001", req_ready);
        end
        @(negedge clk); set_req(0, 1'b0, 1'b0, '0, '0); settle();
        checks++;
        if (req_ready !== 4'b0010) begin
            errors++; $display("FAIL hold_second: got %b required 0010", req_ready);
        end
        @(negedge clk); drive_idle(); settle();
        checks++;
        if ({bank_banksel, bank_read, bank_address} !== {2'b11, 10'h030}) begin
            errors++; $display("FAIL hold_pins: sel=%b rd=%b addr=%h required 1 1 030", bank_banksel, bank_read, bank_address);
        end
        @(negedge clk); settle();
        checks++;
        if ({bank_banksel, bank_read, bank_write, bank_address, rsp_valid, rsp_data} !== {3'b000, 10'h030, 4'b0010, 32'h0}) begin
            errors++;
            $display("FAIL hold_idle: sel=%b rd=%b wr=%b addr=%h rsp=%b data=%h required 0 0 0 030 0010 0",
                     bank_banksel, bank_read, bank_write, bank_address, rsp_valid, rsp_data);
        end
    endtask

    task automatic test_reset_mid_read();
        apply_reset();
        @(negedge clk); drive_idle(); set_req(1, 1'b1, 1'b0, 10'h3FF, '0); settle();
        checks++;
        if (req_ready !== 4'b0010) begin
            errors++; $display("FAIL mid_grant: got %b required 0010", req_ready);
        end
        @(negedge clk); drive_idle(); reset = 1'b1; #1;
        checks++;
        if ({bank_banksel, bank_read, rsp_valid} !== 6'b0) begin
            errors++; $display("FAIL mid_async: sel=%b rd=%b rsp=%b required 0", bank_banksel, bank_read, rsp_valid);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); drive_idle();
            if (i == 0) begin
                set_req(0, 1'b1, 1'b0, 10'h100, '0);
                set_req(3, 1'b1, 1'b0, 10'h100, '0);
            end
            settle();
            if (i == 0) begin
                checks++;
                if (req_ready !== 4'b0001) begin
                    errors++; $display("FAIL mid_ptr: got %b required 0001", req_ready);
                end
            end
            checks++;
            if (rsp_valid !== ((i == 2) ? 4'b0001 : 4'b0000)) begin
                errors++; $display("FAIL mid_rsp[%0d]: got %b required %b", i, rsp_valid, (i == 2) ? 4'b0001 : 4'b0000);
            end
        end
    endtask

    task automatic test_random();
        logic [N-1:0] granted;
        int wait_cnt [N];
        int max_wait;
        granted = '1;
        max_wait = 0;
        for (int i = 0; i < N; i++) wait_cnt[i] = 0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (c >= 390) begin
                    set_req(i, 1'b0, 1'b0, '0, '0);
                end else if (req_valid[i] && !granted[i]) begin
                    if ($urandom_range(0, 15) == 0) req_valid[i] = 1'b0;
                end else begin
                    set_req(i, ($urandom_range(0, 99) < 60), $urandom_range(0, 1) == 1,
                            AW'($urandom_range(0, 15)), $urandom);
                end
            end
            settle();
            checks++;
            if (req_ready !== e_ready) begin
                errors++; $display("FAIL rnd_grant[%0d]: got %b required %b (valid %b)", c, req_ready, e_ready, req_valid);
            end
            checks++;
            if ({bank_banksel, bank_read, bank_write, bank_address, bank_wd} !== {e_sel, e_rd, e_wr, e_addr, e_wd}) begin
                errors++;
                $display("FAIL rnd_pins[%0d]: sel/rd/wr=%b%b%b addr=%h wd=%h required %b%b%b %h %h",
                         c, bank_banksel, bank_read, bank_write, bank_address, bank_wd, e_sel, e_rd, e_wr, e_addr, e_wd);
            end
            checks++;
            if (rsp_valid !== e_rsp_valid || (e_rsp_valid != '0 && rsp_data !== e_rsp_data)) begin
                errors++;
                $display("FAIL rnd_rsp[%0d]: rsp=%b data=%h required %b %h", c, rsp_valid, rsp_data, e_rsp_valid, e_rsp_data);
            end
            granted = req_ready;
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] || req_ready[i]) wait_cnt[i] = 0;
                else if (req_ready != '0) wait_cnt[i]++;
                if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
            end
        end
        checks++;
        if (max_wait > N - 1) begin
            errors++; $display("FAIL fairness: longest wait %0d grants, required at most %0d", max_wait, N - 1);
        end
    endtask

    initial begin
        for (int a = 0; a < 1024; a++) begin
            bank_mem[a] = '0;
            m_mem[a] = '0;
        end
        model_reset();
        test_reset();
        test_write_read();
        test_alternate();
        test_pair23();
        test_war();
        test_hold();
        test_reset_mid_read();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/srambank_arbiter.md
Name: srambank_arbiter

Overview:
Shares one srambank_256x4x32_6t122 instance (1024 x 32, synchronous, 1-cycle read) among NUM_REQ requesters. Round-robin arbitration with per-requester valid/ready request channels. Registers the winning command onto the bank pins and routes the read data back to its originator with a tagged response strobe. Sits between the core-side masters and the bank macro.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
AW, 10, address width (matches the 1024-entry bank)
DW, 32, data width
IDW, 3, requester index width, >= clog2(NUM_REQ), fixed at 3 for 8 requesters

Ports:
clk  in  1  rising-edge clock shared with the bank
reset  in  1  asynchronous, active-high
req_valid  in  NUM_REQ  request pending, one bit per requester
req_ready  out  NUM_REQ  one-hot grant; a request is accepted when valid&ready
req_write  in  NUM_REQ  1=write, 0=read, per requester
req_addr  in  NUM_REQ*AW  packed addresses; requester i occupies bits [i*AW +: AW]
req_wdata  in  NUM_REQ*DW  packed write data; same packing as req_addr
rsp_valid  out  NUM_REQ  one-cycle read-response strobe for the originating requester
rsp_data  out  DW  read data, shared by all requesters, qualified by rsp_valid
bank_address  out  AW  to bank ADDRESS
bank_wd  out  DW  to bank wd
bank_banksel  out  1  to bank banksel
bank_read  out  1  to bank read
bank_write  out  1  to bank write
bank_dataout  in  DW  from bank dataout

Behaviour:
- Reset (async assert, sync release): rr_ptr=0; bank_banksel, bank_read and bank_write=0; bank_address and bank_wd=0; rsp_valid=0; the in-flight read tag is cleared.
- Arbitration (combinational): search req_valid starting at rr_ptr, wrapping modulo NUM_REQ. The first set bit wins. req_ready is one-hot at the winner, or all-zero if no request is valid.
- req_ready never depends on req_write. The arbiter accepts one request every cycle with no bubbles.
- On accept in cycle T: rr_ptr <= (winner+1) mod NUM_REQ. With no accept, rr_ptr holds.
- Cycle T+1: the registered bank pins carry the command. bank_banksel=1. bank_write=req_write. bank_read=~req_write. bank_address and bank_wd take the winner's values.
- With no accept in T: banksel, read and write are 0 in T+1, and address/wd hold their last values.
- The bank executes at the end of T+1.
- Read: the tag register (valid bit plus IDW-bit index) is set in T+1 and advances one stage to align with bank_dataout. In T+2, rsp_valid[idx]=1 for exactly one cycle and rsp_data=bank_dataout passes straight through. Read latency from accept to response is 2 cycles.
- Write: no response strobe. A read accepted in the cycle after a write to the same address returns the new data, because bank ordering is preserved.
- bank_read and bank_write are never both 1. Exactly one command is issued per accept.
- Back-to-back reads from different requesters produce consecutive rsp_valid pulses in issue order. There is no response backpressure; requesters must sink rsp_data in the strobe cycle.
- rsp_data outside an rsp_valid cycle is don't-care (it reflects bank_dataout).
- Fairness: a continuously asserting requester waits at most NUM_REQ-1 grants.
- Reset mid-operation: in-flight commands and tags are discarded, no rsp_valid follows, and bank contents are undefined from the block's view.
- A requester that drops req_valid without handshake loses nothing. Requesters must hold addr, wdata and write stable while valid&~ready.

Decomposition:
- Shared package sram_pkg: AW/DW constants for the bank geometry (1024x32) and a localparam computing IDW. Also a req_cmd_t struct {write, addr, wdata}.
- One sub-module: rr_arbiter (NUM_REQ-wide round-robin picker). Inputs: req vector, rr_ptr. Outputs: one-hot grant, encoded index. Reusable for other shared banks.
- The command register and tag pipeline stay in srambank_arbiter.

Test Plan:
- Reset, then idle: all outputs 0. Assert reset mid-read (between accept and T+2): no rsp_valid appears; rr_ptr returns to 0.
- Req0 write addr 0x3FF data 0xDEADBEEF in cycle 1; req0 read 0x3FF in cycle 2 -> bank_write=1 in cycle 2; rsp_valid[0]=1 with rsp_data=0xDEADBEEF in cycle 4.
- Both requesters valid continuously, reads, for 6 cycles -> grants alternate 0,1,0,1,0,1. rsp_valid alternates with 2-cycle lag. req_ready is always one-hot.
- NUM_REQ=4: only req2 and req3 valid, rr_ptr=0 -> req2 granted first, then req3, then req2. rr_ptr wraps 3->0 correctly.
- Write-after-read to the same addr 0x010 (old 0x11111111, new 0x22222222) in consecutive cycles -> the read response returns 0x11111111; a subsequent read returns 0x22222222.
- Hold: req1 valid with ready low while req0 is being serviced; addr is stable -> req1 is accepted the next cycle. bank_banksel=0 in any cycle following no accept.
